// File: rtl/mu0_mux_arb.sv
// N-channel registered multiplexer with arbitration and a one-entry valid/ready output stage.
// Define MU0_MUX_ARB_RR_EN for round-robin arbitration; otherwise the lowest requesting index wins.
module mu0_mux_arb #(
  parameter int unsigned WIDTH    = 12,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SELW     = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CHANNELS-1:0]         req,
  input  logic [CHANNELS*WIDTH-1:0]   data,
  output logic [CHANNELS-1:0]         ack,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  output logic [SELW-1:0]             out_sel,
  input  logic                        out_ready
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic [SELW-1:0]   ptr_q, ptr_d;

  logic [WIDTH-1:0]  chan_data [CHANNELS];
  logic              load;
  logic              any_req;
  logic              found;
  logic [SELW-1:0]   cand;
  logic [SELW-1:0]   win;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_unpack
    assign chan_data[g] = data[g*WIDTH +: WIDTH];
  end

  // Capture enable and winner selection.
  always_comb begin
    load    = (state_q == EMPTY) || out_ready;
    any_req = |req;
    found   = 1'b0;
    cand    = '0;
    win     = '0;
`ifdef MU0_MUX_ARB_RR_EN
    for (int unsigned k = 1; k <= CHANNELS; k++) begin
      cand = SELW'((32'(ptr_q) + k) % CHANNELS);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
`else
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      cand = SELW'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= SELW'(CHANNELS - 1);
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (load) begin
      if (any_req) begin
        state_d = FULL;
        data_d  = chan_data[win];
        sel_d   = win;
        ptr_d   = win;
      end else begin
        state_d = EMPTY;
      end
    end
  end

  always_comb begin
    ack = '0;
    if (!reset && load && any_req) begin
      ack[win] = 1'b1;
    end
    out_valid = (state_q == FULL);
    out_data  = data_q;
    out_sel   = sel_q;
  end

endmodule
